// File: rtl/gnrc_fractional_pkg.sv
// rtl/gnrc_fractional_pkg.sv - shared types for the fractional rate meter
// Contents: rate_meter_state_e (measurement FSM states).
package gnrc_fractional_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } rate_meter_state_e;

endpackage

// File: rtl/gnrc_fractional_rate_meter_if.sv
// rtl/gnrc_fractional_rate_meter_if.sv - control/result bundle of the rate meter
// Control (master -> slave): en_i, start_i, abort_i, k_i[K_W], tick_i
// Results (slave -> master): busy_o, valid_o, err_o, total_o[N+K_W], min_o[N], max_o[N]
interface gnrc_fractional_rate_meter_if #(
    parameter int N   = 16,
    parameter int K_W = 8
);
    localparam int ACC_W = N + K_W;

    logic             en_i;
    logic             start_i;
    logic             abort_i;
    logic [K_W-1:0]   k_i;
    logic             tick_i;
    logic             busy_o;
    logic             valid_o;
    logic             err_o;
    logic [ACC_W-1:0] total_o;
    logic [N-1:0]     min_o;
    logic [N-1:0]     max_o;

    modport master (
        output en_i, start_i, abort_i, k_i, tick_i,
        input  busy_o, valid_o, err_o, total_o, min_o, max_o
    );

    modport slave (
        input  en_i, start_i, abort_i, k_i, tick_i,
        output busy_o, valid_o, err_o, total_o, min_o, max_o
    );

endinterface

// File: rtl/gnrc_interval_timer.sv
// rtl/gnrc_interval_timer.sv - N-bit saturating interval counter
// clk_i, srst_i : clock, synchronous active-high reset
// load_i        : restart the interval at 1 (has priority over en_i)
// en_i          : count one more clock, holds at all-ones
// cnt_o, sat_o  : current interval length, high when counter is at all-ones
module gnrc_interval_timer #(
    parameter int N = 16
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic         load_i,
    input  logic         en_i,
    output logic [N-1:0] cnt_o,
    output logic         sat_o
);

    assign sat_o = (cnt_o == {N{1'b1}});

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_o <= '0;
        end else if (load_i) begin
            // The clock carrying the tick already counts as the first clock
            // of the new interval.
            cnt_o <= N'(1);
        end else if (en_i && !sat_o) begin
            cnt_o <= cnt_o + N'(1);
        end
    end

endmodule

// File: rtl/gnrc_fractional_rate_meter.sv
// rtl/gnrc_fractional_rate_meter.sv - measures clocks spanned by k tick intervals
// clk_i, srst_i : clock, synchronous active-high reset
// bus (slave)   : en/start/abort/k/tick in; busy/valid/err/total/min/max out
// Results are one-shot per start and held until the next completed measurement.
module gnrc_fractional_rate_meter
    import gnrc_fractional_pkg::*;
#(
    parameter int N   = 16,
    parameter int K_W = 8
) (
    input  logic                        clk_i,
    input  logic                        srst_i,
    gnrc_fractional_rate_meter_if.slave bus
);

    localparam int ACC_W = N + K_W;

    rate_meter_state_e state_q, state_d;

    logic [K_W-1:0]   k_q;
    logic [K_W-1:0]   pcnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [N-1:0]     mn_q;
    logic [N-1:0]     mx_q;
    logic             err_q;

    logic [N-1:0]     icnt;
    logic             icnt_sat;
    logic [K_W:0]     pcnt_inc;

    logic             ref_take;
    logic             tick_take;
    logic             sat_hit;
    logic             icnt_inc;

    assign pcnt_inc = {1'b0, pcnt_q} + (K_W+1)'(1);

    // Abort always wins over a tick in the same cycle.
    assign icnt_inc = (state_q == MEASURE) && bus.en_i && !bus.tick_i && !bus.abort_i;

    gnrc_interval_timer #(.N(N)) u_timer (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .load_i (ref_take | tick_take),
        .en_i   (icnt_inc),
        .cnt_o  (icnt),
        .sat_o  (icnt_sat)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ref_take  = 1'b0;
        tick_take = 1'b0;
        sat_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = (bus.k_i == '0) ? DONE : ARM;
                end
            end
            ARM: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (bus.en_i && bus.tick_i) begin
                    ref_take = 1'b1;
                    state_d  = MEASURE;
                end
            end
            MEASURE: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (bus.en_i) begin
                    if (bus.tick_i) begin
                        // A tick landing on a saturated counter still closes
                        // a valid interval, so it is checked first.
                        tick_take = 1'b1;
                        if (pcnt_inc == {1'b0, k_q}) begin
                            state_d = DONE;
                        end
                    end else if (icnt_sat) begin
                        sat_hit = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            k_q         <= '0;
            pcnt_q      <= '0;
            acc_q       <= '0;
            mn_q        <= '0;
            mx_q        <= '0;
            err_q       <= 1'b0;
            bus.valid_o <= 1'b0;
            bus.err_o   <= 1'b0;
            bus.total_o <= '0;
            bus.min_o   <= '0;
            bus.max_o   <= '0;
        end else begin
            bus.valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        k_q   <= bus.k_i;
                        err_q <= (bus.k_i == '0);
                        // A zero request goes straight to DONE and must
                        // report zeroed totals.
                        if (bus.k_i == '0) begin
                            acc_q <= '0;
                            mn_q  <= '0;
                            mx_q  <= '0;
                        end
                    end
                end
                ARM: begin
                    if (ref_take) begin
                        acc_q  <= '0;
                        pcnt_q <= '0;
                        mn_q   <= {N{1'b1}};
                        mx_q   <= '0;
                    end
                end
                MEASURE: begin
                    if (tick_take) begin
                        acc_q  <= acc_q + {{K_W{1'b0}}, icnt};
                        mn_q   <= (icnt < mn_q) ? icnt : mn_q;
                        mx_q   <= (icnt > mx_q) ? icnt : mx_q;
                        pcnt_q <= pcnt_inc[K_W-1:0];
                    end
                    if (sat_hit) begin
                        err_q <= 1'b1;
                    end
                end
                DONE: begin
                    bus.valid_o <= 1'b1;
                    bus.err_o   <= err_q;
                    bus.total_o <= acc_q;
                    bus.min_o   <= mn_q;
                    bus.max_o   <= mx_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_gnrc_fractional_rate_meter.sv
// tb/tb_gnrc_fractional_rate_meter.sv - scoreboard bench for gnrc_fractional_rate_meter
module tb_gnrc_fractional_rate_meter;

    localparam int N   = 16;
    localparam int K_W = 8;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] total;
        logic [31:0] mn;
        logic [31:0] mx;
    } exp_t;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    gnrc_fractional_rate_meter_if #(.N(N), .K_W(K_W)) bus ();

    gnrc_fractional_rate_meter #(.N(N), .K_W(K_W)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    // Reference tick source: behaves like gnrc_fractional_counter overflow_o.
    logic [7:0] nco_acc = 8'd0;
    logic [7:0] nco_inc;
    logic [7:0] nco_max;
    logic       nco_tick;
    logic       tick_mode;
    logic       man_tick;

    assign nco_tick = ({1'b0, nco_acc} + {1'b0, nco_inc}) >= {1'b0, nco_max};
    always @(posedge clk) begin
        if (nco_tick) nco_acc <= nco_acc + nco_inc - nco_max;
        else          nco_acc <= nco_acc + nco_inc;
    end
    assign bus.tick_i = tick_mode ? nco_tick : man_tick;

    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            exp_t e;
            valid_cnt++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed valid_o=1 expected no result");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.tag, "_err"},   32'(bus.err_o),   32'(e.err));
                chk({e.tag, "_total"}, 32'(bus.total_o), e.total);
                chk({e.tag, "_min"},   32'(bus.min_o),   e.mn);
                chk({e.tag, "_max"},   32'(bus.max_o),   e.mx);
            end
        end
    end

    task automatic do_start(input int k);
        bus.k_i     = K_W'(k);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic step(input logic t, input logic e);
        man_tick = t;
        bus.en_i = e;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget, output int lat);
        lat = 0;
        while (bus.valid_o !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        assert (bus.valid_o === 1'b1) else begin
            errors++;
            $error("FAIL %s_timeout observed valid_o=%b expected 1 within %0d cycles", tag, bus.valid_o, budget);
        end
    endtask

    initial begin
        int lat;
        int vc;

        srst        = 1'b1;
        bus.en_i    = 1'b1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.k_i     = '0;
        tick_mode   = 1'b0;
        man_tick    = 1'b0;
        nco_inc     = 8'd3;
        nco_max     = 8'd26;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(bus.busy_o),  0);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_total", 32'(bus.total_o), 0);
        chk("rst_min",   32'(bus.min_o),   0);
        chk("rst_max",   32'(bus.max_o),   0);
        srst = 1'b0;
        @(negedge clk);

        // NCO inc=3 max=26: three intervals span exactly one 26-clock period.
        tick_mode = 1'b1;
        sb.push_back('{"nco_3_26", 1'b0, 32'd26, 32'd8, 32'd9});
        do_start(3);
        wait_valid("nco_3_26", 200, lat);
        @(negedge clk);

        nco_inc = 8'd5;
        nco_max = 8'd16;
        sb.push_back('{"nco_5_16", 1'b0, 32'd16, 32'd3, 32'd4});
        do_start(5);
        wait_valid("nco_5_16", 200, lat);
        @(negedge clk);

        // tick held high: reference one edge after start, valid five edges later.
        tick_mode = 1'b0;
        man_tick  = 1'b1;
        sb.push_back('{"held_high", 1'b0, 32'd4, 32'd1, 32'd1});
        do_start(4);
        wait_valid("held_high", 20, lat);
        chk("held_high_latency", 32'(lat), 32'd6);
        man_tick = 1'b0;
        @(negedge clk);

        // k=0: DONE right after start, zeroed totals with err.
        sb.push_back('{"k_zero", 1'b1, 32'd0, 32'd0, 32'd0});
        do_start(0);
        chk("k_zero_busy", 32'(bus.busy_o), 1);
        wait_valid("k_zero", 10, lat);
        chk("k_zero_latency", 32'(lat), 32'd1);
        @(negedge clk);

        // en_i low for 10 cycles freezes the interval and drops ticks: 4 + 5.
        sb.push_back('{"en_freeze", 1'b0, 32'd9, 32'd4, 32'd5});
        do_start(2);
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step((i % 3) == 0, 1'b0);
        repeat (2) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        man_tick = 1'b0;
        wait_valid("en_freeze", 10, lat);
        @(negedge clk);

        // abort mid-MEASURE: no result, previous results kept.
        tick_mode = 1'b1;
        nco_inc   = 8'd3;
        nco_max   = 8'd26;
        do_start(3);
        repeat (12) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_busy", 32'(bus.busy_o), 0);
        vc = valid_cnt;
        repeat (40) @(negedge clk);
        chk("abort_no_valid", 32'(valid_cnt - vc), 0);
        chk("abort_total", 32'(bus.total_o), 32'd9);
        chk("abort_min",   32'(bus.min_o),   32'd4);
        chk("abort_max",   32'(bus.max_o),   32'd5);

        // synchronous reset mid-MEASURE clears all outputs.
        do_start(3);
        repeat (12) @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        chk("srst_busy",  32'(bus.busy_o),  0);
        chk("srst_valid", 32'(bus.valid_o), 0);
        chk("srst_total", 32'(bus.total_o), 0);
        chk("srst_min",   32'(bus.min_o),   0);
        chk("srst_max",   32'(bus.max_o),   0);
        srst = 1'b0;
        @(negedge clk);

        // Reference tick then silence: interval saturates, partial results with err.
        tick_mode = 1'b0;
        sb.push_back('{"saturate", 1'b1, 32'd0, 32'd65535, 32'd0});
        do_start(1);
        step(1'b1, 1'b1);
        man_tick = 1'b0;
        wait_valid("saturate", 70000, lat);
        chk("saturate_latency", 32'(lat), 32'd65536);
        @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
